// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a data port (single read/write) and a fetch port
// (two-beat read at addr, addr+4) share one memory bus, with fetch starvation bounded.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_valid,
   output logic [63:0] i_data,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      D_ACC,
      I_BEAT0,
      I_BEAT1
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;
   logic             grant_d;
   logic             grant_i;
   logic             d_valid_q;
   logic             i_valid_q;
   logic [31:0]      d_rdata_q;
   logic [31:0]      beat0_q;
   logic [63:0]      i_data_q;
   logic             mem_en_q;
   logic             mem_we_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_wdata_q;

   // Grants are decided combinationally in IDLE so they pulse in the request cycle;
   // gating with rst keeps them low while reset is asserted.
   assign grant_d = rst && (state_q == IDLE) && d_req && (!i_req || (starve_q < STARVE_LIM));
   assign grant_i = rst && (state_q == IDLE) && i_req && !grant_d;

   always_comb begin
      starve_d = starve_q;
      if (!i_req) begin
         starve_d = '0;
      end else if (grant_d && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + CNT_W'(1);
      end else if (grant_i) begin
         starve_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         d_valid_q   <= 1'b0;
         i_valid_q   <= 1'b0;
         d_rdata_q   <= '0;
         beat0_q     <= '0;
         i_data_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         starve_q  <= starve_d;
         d_valid_q <= 1'b0;
         i_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  state_q     <= D_ACC;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= d_we;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
               end else if (grant_i) begin
                  state_q     <= I_BEAT0;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= i_addr;
                  mem_wdata_q <= '0;
               end
            end
            D_ACC: begin
               if (mem_ack) begin
                  if (!mem_we_q) begin
                     d_rdata_q <= mem_rdata;
                  end
                  d_valid_q   <= 1'b1;
                  state_q     <= IDLE;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end
            end
            I_BEAT0: begin
               if (mem_ack) begin
                  beat0_q    <= mem_rdata;
                  mem_addr_q <= mem_addr_q + 32'd4;
                  state_q    <= I_BEAT1;
               end
            end
            I_BEAT1: begin
               if (mem_ack) begin
                  i_data_q    <= {mem_rdata, beat0_q};
                  i_valid_q   <= 1'b1;
                  state_q     <= IDLE;
                  mem_en_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign d_gnt     = grant_d;
   assign i_gnt     = grant_i;
   assign d_valid   = d_valid_q;
   assign i_valid   = i_valid_q;
   assign d_rdata   = d_rdata_q;
   assign i_data    = i_data_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset and starvation sequences,
// then random traffic checked against a transaction-level scoreboard.
module tb_mem_arbiter;

   localparam int unsigned SMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_gnt, i_valid;
   logic [31:0] i_addr;
   logic [63:0] i_data;
   logic        d_req, d_we, d_gnt, d_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_data(i_data),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic inputs_zero();
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " ctl"}, 64'({i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_we}), 64'(0));
      chk({tag, " i_data"}, i_data, 64'(0));
      chk({tag, " d_rdata/mem_addr"}, 64'({d_rdata, mem_addr}), 64'(0));
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
   endtask

   // Requests are held high during reset to show grants stay gated off.
   task automatic do_reset();
      inputs_zero();
      d_req = 1'b1; i_req = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      inputs_zero();
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   typedef struct {
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        i_req;
      logic [31:0] i_addr;
      logic        ack;
      logic [31:0] rdata;
      logic        e_dg, e_ig, e_dv, e_iv, e_en, e_we;
      logic [31:0] e_addr, e_wdata, e_drdata;
      logic [63:0] e_idata;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      bit          fetch;
      bit          last;
   } acc_t;

   vec_t tbl[17];

   initial begin
      string       got;
      string       pat;
      acc_t        accq[$];
      acc_t        a;
      bit          busy, e_dg, e_ig, pend_dv, pend_iv, dg_seen, ig_seen;
      logic [31:0] m_drdata, beat0;
      logic [63:0] m_idata;
      int unsigned starve;

      // fields: d_req d_we d_addr d_wdata i_req i_addr ack rdata | dg ig dv iv en we addr wdata d_rdata i_data
      tbl[0]  = '{1,0,32'h100,0, 0,0, 0,0,               1,0,0,0, 0,0,0,0,                      0,0};
      tbl[1]  = '{0,0,0,0, 0,0, 1,32'hDEADBEEF,          0,0,0,0, 1,0,32'h100,0,                0,0};
      tbl[2]  = '{0,0,0,0, 0,0, 0,0,                     0,0,1,0, 0,0,0,0,                      32'hDEADBEEF,0};
      tbl[3]  = '{1,1,32'h8,32'h55, 0,0, 0,0,            1,0,0,0, 0,0,0,0,                      32'hDEADBEEF,0};
      tbl[4]  = '{0,0,0,0, 0,0, 0,0,                     0,0,0,0, 1,1,32'h8,32'h55,             32'hDEADBEEF,0};
      tbl[5]  = tbl[4];
      tbl[6]  = tbl[4];
      tbl[7]  = '{0,0,0,0, 0,0, 1,32'h12345678,          0,0,0,0, 1,1,32'h8,32'h55,             32'hDEADBEEF,0};
      tbl[8]  = '{0,0,0,0, 0,0, 1,32'hBAD0BAD0,          0,0,1,0, 0,0,0,0,                      32'hDEADBEEF,0};
      tbl[9]  = '{0,0,0,0, 1,32'h20, 0,0,                0,1,0,0, 0,0,0,0,                      32'hDEADBEEF,0};
      tbl[10] = '{0,0,0,0, 0,0, 1,32'h11111111,          0,0,0,0, 1,0,32'h20,0,                 32'hDEADBEEF,0};
      tbl[11] = '{0,0,0,0, 0,0, 1,32'h22222222,          0,0,0,0, 1,0,32'h24,0,                 32'hDEADBEEF,0};
      tbl[12] = '{0,0,0,0, 1,32'hFFFFFFFC, 0,0,          0,1,0,1, 0,0,0,0,                      32'hDEADBEEF,64'h2222222211111111};
      tbl[13] = '{0,0,0,0, 0,0, 0,0,                     0,0,0,0, 1,0,32'hFFFFFFFC,0,           32'hDEADBEEF,64'h2222222211111111};
      tbl[14] = '{0,0,0,0, 0,0, 1,32'hA5A5A5A5,          0,0,0,0, 1,0,32'hFFFFFFFC,0,           32'hDEADBEEF,64'h2222222211111111};
      tbl[15] = '{0,0,0,0, 0,0, 1,32'h5A5A5A5A,          0,0,0,0, 1,0,32'h00000000,0,           32'hDEADBEEF,64'h2222222211111111};
      tbl[16] = '{0,0,0,0, 0,0, 0,0,                     0,0,0,1, 0,0,0,0,                      32'hDEADBEEF,64'h5A5A5A5AA5A5A5A5};

      inputs_zero();
      rst = 1'b0;
      do_reset();

      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
         i_req = tbl[i].i_req; i_addr = tbl[i].i_addr; mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
         @(negedge clk);
         chk($sformatf("vec%0d ctl", i), 64'({d_gnt, i_gnt, d_valid, i_valid, mem_en, mem_we}),
             64'({tbl[i].e_dg, tbl[i].e_ig, tbl[i].e_dv, tbl[i].e_iv, tbl[i].e_en, tbl[i].e_we}));
         if (tbl[i].e_en) begin
            chk($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_wdata));
         end
         chk($sformatf("vec%0d d_rdata", i), 64'(d_rdata), 64'(tbl[i].e_drdata));
         chk($sformatf("vec%0d i_data", i), i_data, tbl[i].e_idata);
      end

      // Reset while the second fetch beat is outstanding.
      @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h40; mem_ack = 1'b0;
      @(negedge clk); chk("midrst gnt", 64'(i_gnt), 64'(1));
      @(posedge clk); #1 i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
      @(negedge clk); chk("midrst beat0", 64'({mem_en, mem_addr}), 64'({1'b1, 32'h40}));
      @(posedge clk); #1 mem_ack = 1'b0;
      @(negedge clk); chk("midrst beat1", 64'({mem_en, mem_addr}), 64'({1'b1, 32'h44}));
      #2 rst = 1'b0;
      #1 check_zero("midrst async");
      mem_ack = 1'b1; mem_rdata = 32'h99;
      repeat (2) @(posedge clk);
      #1 check_zero("midrst held");
      @(negedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("midrst quiet%0d", i), 64'({i_valid, d_valid, mem_en}), 64'(0));
      end
      @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h80; mem_ack = 1'b0;
      @(negedge clk); chk("post-rst first gnt", 64'(i_gnt), 64'(1));

      // Both requesters held: grant pattern must be DDDDI repeating.
      do_reset();
      @(posedge clk); #1;
      d_req = 1'b1; d_addr = 32'h200; i_req = 1'b1; i_addr = 32'h300; mem_ack = 1'b1; mem_rdata = 32'h1;
      got = "";
      pat = "DDDDIDDDDI";
      for (int cyc = 0; cyc < 80 && got.len() < 10; cyc++) begin
         @(negedge clk);
         if (d_gnt && i_gnt) got = {got, "X"};
         else if (d_gnt) got = {got, "D"};
         else if (i_gnt) got = {got, "I"};
      end
      for (int i = 0; i < 10; i++)
         chk($sformatf("starve grant%0d", i), 64'((i < got.len()) ? got[i] : 8'd0), 64'(pat[i]));

      // Random traffic against a scoreboard of pending memory accesses.
      do_reset();
      m_drdata = '0; m_idata = '0; beat0 = '0; starve = 0;
      pend_dv = 1'b0; pend_iv = 1'b0; dg_seen = 1'b0; ig_seen = 1'b0;
      accq.delete();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (!d_req || dg_seen) begin
            d_req = ($urandom_range(0, 99) < 60); d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom; d_wdata = $urandom;
         end
         if (!i_req || ig_seen) begin
            i_req = ($urandom_range(0, 99) < 50);
            i_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
         end
         mem_ack = ($urandom_range(0, 99) < 45); mem_rdata = $urandom;
         @(negedge clk);
         busy = (accq.size() > 0);
         e_dg = !busy && d_req && (!i_req || starve < SMAX);
         e_ig = !busy && i_req && !e_dg;
         chk($sformatf("rnd%0d ctl", c), 64'({d_gnt, i_gnt, d_valid, i_valid, mem_en, mem_we}),
             64'({e_dg, e_ig, pend_dv, pend_iv, busy, busy ? accq[0].we : 1'b0}));
         if (busy) begin
            chk($sformatf("rnd%0d mem_addr", c), 64'(mem_addr), 64'(accq[0].addr));
            if (accq[0].we) chk($sformatf("rnd%0d mem_wdata", c), 64'(mem_wdata), 64'(accq[0].wdata));
         end
         chk($sformatf("rnd%0d d_rdata", c), 64'(d_rdata), 64'(m_drdata));
         chk($sformatf("rnd%0d i_data", c), i_data, m_idata);
         dg_seen = e_dg; ig_seen = e_ig;
         pend_dv = 1'b0; pend_iv = 1'b0;
         if (busy && mem_ack) begin
            a = accq.pop_front();
            if (a.fetch && !a.last) beat0 = mem_rdata;
            else if (a.fetch) begin m_idata = {mem_rdata, beat0}; pend_iv = 1'b1; end
            else begin if (!a.we) m_drdata = mem_rdata; pend_dv = 1'b1; end
         end
         if (!i_req) starve = 0;
         else if (e_dg) starve = (starve < SMAX) ? starve + 1 : SMAX;
         else if (e_ig) starve = 0;
         if (e_dg) accq.push_back('{d_addr, d_we, d_wdata, 1'b0, 1'b1});
         if (e_ig) begin
            accq.push_back('{i_addr, 1'b0, 32'h0, 1'b1, 1'b0});
            accq.push_back('{i_addr + 32'd4, 1'b0, 32'h0, 1'b1, 1'b1});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
